// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS fetch stage: PC, in-order imem requests, {instr, pc4} queue, jump redirect
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReqValidOutput,
    input  logic        imemReqReadyInput,
    output logic [31:0] imemAddrOutput,
    input  logic        imemRespValidInput,
    input  logic [31:0] imemRespDataInput,
    output logic [31:0] instructionOutput,
    output logic [31:0] pc4Output,
    output logic        instructionValidOutput,
    input  logic        stallInput,
    input  logic        jumpInput,
    input  logic [31:0] pcJumpInput
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc4   [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;

    logic          w_req_valid;
    logic          w_accept;
    logic          w_resp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_live;
    logic [CW-1:0] w_inflight_next;

    // Live in-flight words are already promised queue slots, so they count against capacity.
    assign w_live          = r_inflight - r_discard;
    assign w_req_valid     = reset && !jumpInput && (r_inflight < DEPTH_C)
                             && (({1'b0, r_count} + {1'b0, w_live}) < {1'b0, DEPTH_C});
    assign w_accept        = w_req_valid && imemReqReadyInput;
    assign w_resp          = imemRespValidInput && (r_inflight != '0);
    assign w_drop          = w_resp && (r_discard != '0);
    assign w_push          = w_resp && !w_drop && !jumpInput;
    assign w_pop           = (r_count != '0) && !stallInput && !jumpInput;
    assign w_inflight_next = r_inflight + CW'(w_accept) - CW'(w_resp);

    assign imemReqValidOutput     = w_req_valid;
    assign imemAddrOutput         = r_fetch_pc;
    assign instructionOutput      = r_q_instr[r_head];
    assign pc4Output              = r_q_pc4[r_head];
    assign instructionValidOutput = (r_count != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc4[i]   <= '0;
            end
        end else begin
            r_inflight <= w_inflight_next;
            if (jumpInput) begin
                // Everything still outstanding after this edge belongs to the old stream.
                r_fetch_pc <= pcJumpInput;
                r_resp_pc  <= pcJumpInput;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_discard  <= w_inflight_next;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_drop) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_q_instr[r_tail] <= imemRespDataInput;
                    r_q_pc4[r_tail]   <= r_resp_pc + 32'd4;
                    r_tail            <= r_tail + PW'(1);
                    r_resp_pc         <= r_resp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

endmodule
